// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire scheduler: one shared update datapath
// walks all neurons once per timestep. Define LIF_CHAIN_EN to enable the same-step feed-forward chain.
module lif_tdm_scheduler #(
  parameter int N_NEURONS    = 4,
  parameter int V_WIDTH      = 8,
  parameter int THRESHOLD    = 200,
  parameter int LEAK_SHIFT   = 3,
  parameter int REFRAC       = 2,
  parameter int CHAIN_WEIGHT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step_start,
  input  logic [5*N_NEURONS-1:0] cur_in,
  output logic                   busy,
  output logic                   step_done,
  output logic [N_NEURONS-1:0]   spike_vec,
  output logic                   overrun,
  input  logic [2:0]             v_sel,
  output logic [V_WIDTH-1:0]     v_out
);

  localparam int IDX_W = $clog2(N_NEURONS);
  localparam int REF_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  // Adder wide enough that v + cur + chain never wraps before saturation.
  localparam int SUM_W = $clog2((1 << V_WIDTH) + 31 + CHAIN_WEIGHT);
  localparam logic [SUM_W-1:0]   V_MAX    = SUM_W'((1 << V_WIDTH) - 1);
  localparam logic [V_WIDTH-1:0] THRESH_V = V_WIDTH'(THRESHOLD);
  localparam logic [REF_W-1:0]   REF_INIT = REF_W'(REFRAC);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPDATE, S_COMMIT} state_t;

  state_t                   state_reg, state_next;
  logic [IDX_W-1:0]         idx_reg;
  logic [5*N_NEURONS-1:0]   cur_shadow_reg;
  logic [N_NEURONS-1:0]     scratch_reg;
  logic [N_NEURONS-1:0]     scratch_upd;
  logic [N_NEURONS-1:0]     spike_vec_reg;
  logic                     overrun_reg;
  logic [V_WIDTH-1:0]       v_reg   [N_NEURONS];
  logic [REF_W-1:0]         ref_reg [N_NEURONS];
  logic [4:0]               cur_arr [N_NEURONS];

  logic                     load_en, upd_en, last_idx;
  logic [V_WIDTH-1:0]       v_cur;
  logic [REF_W-1:0]         ref_cur;
  logic [4:0]               cur_sel;
  logic [SUM_W-1:0]         cur_ext;
  logic [SUM_W-1:0]         sum;
  logic [V_WIDTH-1:0]       v_sat;
  logic                     fire;
  logic [V_WIDTH-1:0]       v_new;
  logic [REF_W-1:0]         ref_new;

  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_cur
      assign cur_arr[gi] = cur_shadow_reg[5*gi +: 5];
    end
  endgenerate

  // FSM: state register plus next-state / decoded outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  assign last_idx = (idx_reg == LAST_IDX);

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    step_done  = 1'b0;
    load_en    = 1'b0;
    upd_en     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (step_start) state_next = S_LOAD;
      end
      S_LOAD: begin
        busy       = 1'b1;
        load_en    = 1'b1;
        state_next = S_UPDATE;
      end
      S_UPDATE: begin
        busy   = 1'b1;
        upd_en = 1'b1;
        if (last_idx) state_next = S_COMMIT;
      end
      S_COMMIT: begin
        busy       = 1'b1;
        step_done  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shared neuron update datapath for neuron idx_reg
  assign v_cur   = v_reg[idx_reg];
  assign ref_cur = ref_reg[idx_reg];
  assign cur_sel = cur_arr[idx_reg];

`ifdef LIF_CHAIN_EN
  logic             chain_hit;
  logic [IDX_W-1:0] prev_idx;
  assign prev_idx  = idx_reg - IDX_W'(1);
  // Predecessor was processed earlier this step, so its scratch bit is already current.
  assign chain_hit = (idx_reg != '0) && scratch_reg[prev_idx];
  assign cur_ext   = SUM_W'(cur_sel) + (chain_hit ? SUM_W'(CHAIN_WEIGHT) : '0);
`else
  assign cur_ext   = SUM_W'(cur_sel);
`endif

  assign sum   = SUM_W'(v_cur) - SUM_W'(v_cur >> LEAK_SHIFT) + cur_ext;
  assign v_sat = (sum > V_MAX) ? V_MAX[V_WIDTH-1:0] : sum[V_WIDTH-1:0];
  assign fire  = (ref_cur == '0) && (v_sat >= THRESH_V);

  always_comb begin
    v_new   = v_sat;
    ref_new = '0;
    if (ref_cur != '0) begin
      v_new   = '0;
      ref_new = ref_cur - REF_W'(1);
    end else if (fire) begin
      v_new   = '0;
      ref_new = REF_INIT;
    end
  end

  always_comb begin
    scratch_upd          = scratch_reg;
    scratch_upd[idx_reg] = fire;
  end

  // Per-neuron state registers, written only when the scheduler points at them
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg[gi]   <= '0;
          ref_reg[gi] <= '0;
        end else if (upd_en && (idx_reg == IDX_W'(gi))) begin
          v_reg[gi]   <= v_new;
          ref_reg[gi] <= ref_new;
        end
      end
    end
  endgenerate

  // Spike vector is loaded on the last update edge so it is valid during COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg        <= '0;
      cur_shadow_reg <= '0;
      scratch_reg    <= '0;
      spike_vec_reg  <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      if (load_en) begin
        cur_shadow_reg <= cur_in;
        idx_reg        <= '0;
        scratch_reg    <= '0;
      end
      if (upd_en) begin
        scratch_reg <= scratch_upd;
        idx_reg     <= idx_reg + IDX_W'(1);
        if (last_idx) spike_vec_reg <= scratch_upd;
      end
      if (step_start && (state_reg != S_IDLE)) overrun_reg <= 1'b1;
    end
  end

  assign spike_vec = spike_vec_reg;
  assign overrun   = overrun_reg;

  always_comb begin
    v_out = '0;
    if (32'(v_sel) < N_NEURONS) v_out = v_reg[v_sel[IDX_W-1:0]];
  end

endmodule
